// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: stall-vector layout,
// stall patterns, controller state encoding and instruction address width.
package pipe_stall_ctrl_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned StallBus    = 6;

  localparam int unsigned StallPc    = 0;
  localparam int unsigned StallIfId  = 1;
  localparam int unsigned StallIdEx  = 2;
  localparam int unsigned StallExMem = 3;
  localparam int unsigned StallMemWb = 4;
  localparam int unsigned StallWb    = 5;

  // Each pattern freezes the PC and every pipeline register up to the requester.
  localparam logic [StallBus-1:0] StallPatNone = '0;
  localparam logic [StallBus-1:0] StallPatIf   = StallBus'((1 << StallPc) | (1 << StallIfId));
  localparam logic [StallBus-1:0] StallPatId   = StallPatIf | StallBus'(1 << StallIdEx);
  localparam logic [StallBus-1:0] StallPatMem  = StallPatId | StallBus'((1 << StallExMem) | (1 << StallMemWb));

  typedef enum logic {
    CtrlRun  = 1'b0,
    CtrlPend = 1'b1
  } ctrl_state_e;

  function automatic logic [StallBus-1:0] stall_pattern(
    input logic mem_req,
    input logic flushing,
    input logic id_req,
    input logic if_req
  );
    if (mem_req)       return StallPatMem;
    else if (flushing) return StallPatNone;
    else if (id_req)   return StallPatId;
    else if (if_req)   return StallPatIf;
    else               return StallPatNone;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline-control bundle between the core stages and pipe_stall_ctrl.
// Performance counter signals exist only when STALL_PERF_CNT_EN is defined.
interface pipe_stall_ctrl_if
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
);

  logic                   stallreq_from_if;
  logic                   stallreq_from_id;
  logic                   stallreq_from_mem;
  logic                   branch_taken_i;
  logic [InstAddrBus-1:0] branch_target_i;
  logic [StallBus-1:0]    stall_o;
  logic                   flush_o;
  logic                   redirect_o;
  logic [InstAddrBus-1:0] new_pc_o;
  logic                   hang_o;
`ifdef STALL_PERF_CNT_EN
  logic [CNT_WIDTH-1:0]   stall_cycles_o;
  logic [CNT_WIDTH-1:0]   flush_count_o;
`endif

  if (CNT_WIDTH == 0) begin : g_cnt_width_chk
    $error("pipe_stall_ctrl_if: CNT_WIDTH must be nonzero");
  end

  modport master (
    output stallreq_from_if, stallreq_from_id, stallreq_from_mem,
    output branch_taken_i, branch_target_i,
`ifdef STALL_PERF_CNT_EN
    input  stall_cycles_o, flush_count_o,
`endif
    input  stall_o, flush_o, redirect_o, new_pc_o, hang_o
  );

  modport slave (
    input  stallreq_from_if, stallreq_from_id, stallreq_from_mem,
    input  branch_taken_i, branch_target_i,
`ifdef STALL_PERF_CNT_EN
    output stall_cycles_o, flush_count_o,
`endif
    output stall_o, flush_o, redirect_o, new_pc_o, hang_o
  );

endinterface

// File: rtl/pipe_stall_ctrl_stall_watchdog.sv
// Stall watchdog: counts consecutive PC-stall cycles, saturating at LIMIT,
// and raises a sticky hang flag when the count reaches LIMIT.
module stall_watchdog #(
  parameter int unsigned LIMIT = 1024,
  parameter int unsigned WIDTH = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall_i,
  output logic hang_o
);

  localparam logic [WIDTH-1:0] Limit = WIDTH'(LIMIT);

  logic [WIDTH-1:0] cnt_d, cnt_q;
  logic             hang_d, hang_q;

  always_comb begin
    cnt_d = '0;
    if (stall_i) begin
      cnt_d = (cnt_q == Limit) ? cnt_q : cnt_q + WIDTH'(1);
    end
    hang_d = hang_q | (cnt_d == Limit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      hang_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hang_q <= hang_d;
    end
  end

  assign hang_o = hang_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central 5-stage pipeline controller: merges stall requests, sequences
// branch flushes (deferring them past MEM stalls) and hosts the stall watchdog.
// Optional performance counters are enabled by defining STALL_PERF_CNT_EN.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned WDT_LIMIT = 1024,
  parameter int unsigned WDT_WIDTH = 11,
  parameter int unsigned CNT_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_stall_ctrl_if.slave  bus
);

  if (CNT_WIDTH == 0 || (64'd1 << WDT_WIDTH) <= 64'(WDT_LIMIT)) begin : g_param_chk
    $error("pipe_stall_ctrl: need CNT_WIDTH > 0 and 2**WDT_WIDTH > WDT_LIMIT");
  end

  ctrl_state_e            state_d, state_q;
  logic [InstAddrBus-1:0] target_d, target_q;

  logic                   flush;
  logic                   redirect;
  logic [InstAddrBus-1:0] new_pc;
  logic [StallBus-1:0]    stall;
  logic                   hang;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    flush    = 1'b0;
    redirect = 1'b0;
    new_pc   = '0;
    unique case (state_q)
      CtrlRun: begin
        if (bus.branch_taken_i) begin
          if (!bus.stallreq_from_mem) begin
            flush    = 1'b1;
            redirect = 1'b1;
            new_pc   = bus.branch_target_i;
          end else begin
            state_d  = CtrlPend;
            target_d = bus.branch_target_i;
          end
        end
      end
      CtrlPend: begin
        // EX is frozen while pending, so a fresh branch_taken_i is stale.
        new_pc = target_q;
        if (!bus.stallreq_from_mem) begin
          flush    = 1'b1;
          redirect = 1'b1;
          state_d  = CtrlRun;
        end
      end
      default: state_d = CtrlRun;
    endcase
    stall = stall_pattern(bus.stallreq_from_mem, flush,
                          bus.stallreq_from_id, bus.stallreq_from_if);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= CtrlRun;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  stall_watchdog #(
    .LIMIT (WDT_LIMIT),
    .WIDTH (WDT_WIDTH)
  ) u_stall_watchdog (
    .clk     (clk),
    .rst_n   (rst),
    .stall_i (stall[StallPc]),
    .hang_o  (hang)
  );

`ifdef STALL_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cycles_d, stall_cycles_q;
  logic [CNT_WIDTH-1:0] flush_count_d, flush_count_q;

  always_comb begin
    stall_cycles_d = stall_cycles_q + CNT_WIDTH'(stall[StallPc]);
    flush_count_d  = flush_count_q + CNT_WIDTH'(flush);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign bus.stall_cycles_o = stall_cycles_q;
  assign bus.flush_count_o  = flush_count_q;
`endif

  assign bus.stall_o    = stall;
  assign bus.flush_o    = flush;
  assign bus.redirect_o = redirect;
  assign bus.new_pc_o   = new_pc;
  assign bus.hang_o     = hang;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed vector table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_pipe_stall_ctrl;

  localparam int unsigned WDT_LIM = 8;
  localparam int unsigned WDT_W   = 4;
  localparam int unsigned CW      = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.CNT_WIDTH(CW)) bus ();

  pipe_stall_ctrl #(
    .WDT_LIMIT (WDT_LIM),
    .WDT_WIDTH (WDT_W),
    .CNT_WIDTH (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Current stimulus
  logic        in_mem, in_id, in_if, in_br;
  logic [31:0] in_tgt;

  task automatic drive(input logic mem, input logic id, input logic ifr,
                       input logic br, input logic [31:0] tgt);
    in_mem = mem; in_id = id; in_if = ifr; in_br = br; in_tgt = tgt;
    bus.stallreq_from_mem = mem;
    bus.stallreq_from_id  = id;
    bus.stallreq_from_if  = ifr;
    bus.branch_taken_i    = br;
    bus.branch_target_i   = tgt;
  endtask

  // Behavioural reference: a pending redirect, a stall run length and totals.
  bit          m_pend;
  logic [31:0] m_tgt;
  int unsigned m_run;
  bit          m_hang;
  longint unsigned m_stalls, m_flushes;

  task automatic model_reset();
    m_pend = 0; m_tgt = '0; m_run = 0; m_hang = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic model_outputs(output logic [5:0] s, output logic f,
                               output logic r, output logic [31:0] pc);
    bit go;
    go = m_pend ? !in_mem : (in_br && !in_mem);
    f  = go;
    r  = go;
    pc = m_pend ? m_tgt : (go ? in_tgt : 32'h0);
    if (in_mem)     s = 6'h1f;
    else if (go)    s = 6'h00;
    else if (in_id) s = 6'h07;
    else if (in_if) s = 6'h03;
    else            s = 6'h00;
  endtask

  task automatic model_step();
    logic [5:0] s; logic f, r; logic [31:0] pc;
    model_outputs(s, f, r, pc);
    m_stalls  += longint'(s[0]);
    m_flushes += longint'(f);
    if (m_pend) begin
      if (!in_mem) m_pend = 0;
    end else if (in_br && in_mem) begin
      m_pend = 1;
      m_tgt  = in_tgt;
    end
    if (s[0]) m_run = (m_run < WDT_LIM) ? m_run + 1 : m_run;
    else      m_run = 0;
    if (m_run >= WDT_LIM) m_hang = 1;
  endtask

  task automatic check_all(input string tag);
    logic [5:0] s; logic f, r; logic [31:0] pc;
    model_outputs(s, f, r, pc);
    check({tag, " stall"},    64'(bus.stall_o),    64'(s));
    check({tag, " flush"},    64'(bus.flush_o),    64'(f));
    check({tag, " redirect"}, 64'(bus.redirect_o), 64'(r));
    check({tag, " new_pc"},   64'(bus.new_pc_o),   64'(pc));
    check({tag, " hang"},     64'(bus.hang_o),     64'(m_hang));
`ifdef STALL_PERF_CNT_EN
    check({tag, " stall_cycles"}, 64'(bus.stall_cycles_o), 64'(m_stalls[CW-1:0]));
    check({tag, " flush_count"},  64'(bus.flush_count_o),  64'(m_flushes[CW-1:0]));
`endif
  endtask

  // Inputs change at posedge+1; outputs sampled at negedge; model advances at posedge.
  task automatic cycle(input string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    logic        mem, id, ifr, br;
    logic [31:0] tgt;
    logic [5:0]  stall;
    logic        flush, redir;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,      6'h00, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,      6'h03, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,      6'h07, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,      6'h00, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h1040,   6'h00, 1'b1, 1'b1, 32'h1040};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h2000,   6'h00, 1'b1, 1'b1, 32'h2000};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h3000,   6'h00, 1'b1, 1'b1, 32'h3000};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h200,    6'h1f, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h999,    6'h1f, 1'b0, 1'b0, 32'h200};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,      6'h1f, 1'b0, 1'b0, 32'h200};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      6'h00, 1'b1, 1'b1, 32'h200};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      6'h07, 1'b0, 1'b0, 32'h0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,      6'h1f, 1'b0, 1'b0, 32'h0};

    drive(0, 0, 0, 0, 32'h0);
    model_reset();
    #2;
    check("reset stall",    64'(bus.stall_o),    64'h0);
    check("reset flush",    64'(bus.flush_o),    64'h0);
    check("reset redirect", 64'(bus.redirect_o), 64'h0);
    check("reset new_pc",   64'(bus.new_pc_o),   64'h0);
    check("reset hang",     64'(bus.hang_o),     64'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Directed vector table
    foreach (tbl[i]) begin
      drive(tbl[i].mem, tbl[i].id, tbl[i].ifr, tbl[i].br, tbl[i].tgt);
      @(negedge clk);
      check($sformatf("vec%0d stall", i),    64'(bus.stall_o),    64'(tbl[i].stall));
      check($sformatf("vec%0d flush", i),    64'(bus.flush_o),    64'(tbl[i].flush));
      check($sformatf("vec%0d redirect", i), 64'(bus.redirect_o), 64'(tbl[i].redir));
      check($sformatf("vec%0d new_pc", i),   64'(bus.new_pc_o),   64'(tbl[i].pc));
      check($sformatf("vec%0d hang", i),     64'(bus.hang_o),     64'(m_hang));
      @(posedge clk);
      model_step();
      #1;
    end

    // Watchdog: 8 consecutive IF stalls set hang, which is sticky until reset
    do_reset();
    drive(0, 0, 1, 0, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 7) check("wdt before limit", 64'(bus.hang_o), 64'h0);
    end
    check("wdt at limit", 64'(bus.hang_o), 64'h1);
    drive(0, 0, 0, 0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("wdt sticky", 64'(bus.hang_o), 64'h1);
    rst = 1'b0;
    #1;
    check("wdt reset clears", 64'(bus.hang_o), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset while a redirect is pending discards it
    do_reset();
    drive(1, 0, 0, 1, 32'h200);
    @(posedge clk);
    #1;
    drive(1, 0, 0, 0, 32'h0);
    #2;
    check("pend entered new_pc", 64'(bus.new_pc_o), 64'h200);
    rst = 1'b0;
    #1;
    drive(0, 0, 0, 0, 32'h0);
    #1;
    check("pend rst flush",    64'(bus.flush_o),    64'h0);
    check("pend rst redirect", 64'(bus.redirect_o), 64'h0);
    check("pend rst new_pc",   64'(bus.new_pc_o),   64'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post-pend flush",    64'(bus.flush_o),    64'h0);
      check("post-pend redirect", 64'(bus.redirect_o), 64'h0);
`ifdef STALL_PERF_CNT_EN
      check("post-pend flush_count", 64'(bus.flush_count_o), 64'h0);
`endif
      @(posedge clk);
      #1;
    end

    // Randomized traffic against the model, with occasional resets
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom);
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline controller for the 5-stage core.
- Merges stall requests from IF (memory port busy), ID (load-use hazard from the register-file forwarding logic) and MEM (load/store in flight) into one per-stage stall vector.
- Sequences branch/jump flushes from EX, holding a redirect that collides with a MEM stall until it can be issued.
- Provides a stall watchdog.

Parameters:
- WDT_LIMIT, 1024: consecutive cycles with stall_o[0] high before hang_o sets.
- WDT_WIDTH, 11: watchdog counter width; must satisfy 2^WDT_WIDTH > WDT_LIMIT.
- CNT_WIDTH, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stallreq_from_if  in  1  IF waiting on the memory port.
- stallreq_from_id  in  1  ID operand hazard (load in EX or MEM).
- stallreq_from_mem  in  1  MEM access not complete.
- branch_taken_i  in  1  EX resolved a taken branch or jump this cycle.
- branch_target_i  in  32  redirect PC.
- stall_o  out  6  bit0 pc, 1 if_id, 2 id_ex, 3 ex_mem, 4 mem_wb, 5 wb; 1 = hold register.
- flush_o  out  1  kill IF/ID and ID/EX contents; IF drops its in-flight fetch.
- redirect_o  out  1  PC loads new_pc_o this cycle.
- new_pc_o  out  32  redirect target.
- hang_o  out  1  sticky watchdog flag.

Behaviour:
- Reset, rst low, asynchronous: all outputs 0; state RUN; pending target 0; watchdog 0; hang_o 0.
- Stall vector is combinational from the current requests and state, with priority MEM > branch/flush > ID > IF:
  - stallreq_from_mem: 6'b011111.
  - Else, flush being issued: 6'b000000. The branch kills the ID instruction, so ID and IF stalls are ignored that cycle.
  - Else stallreq_from_id: 6'b000111.
  - Else stallreq_from_if: 6'b000011.
  - Else 6'b000000.
- FSM has 2 states: RUN and PEND.
- RUN:
  - branch_taken_i=1 and stallreq_from_mem=0: flush_o=1, redirect_o=1, new_pc_o=branch_target_i, all combinational, same cycle. Stay in RUN.
  - branch_taken_i=1 and stallreq_from_mem=1: latch branch_target_i at the edge; go to PEND. flush_o and redirect_o stay 0 this cycle.
- PEND:
  - new_pc_o shows the latched target.
  - branch_taken_i is ignored, because EX is frozen by the MEM stall.
  - While stallreq_from_mem=1: stall_o=011111, flush_o=0.
  - First cycle with stallreq_from_mem=0: flush_o=1, redirect_o=1, stall_o=0; return to RUN at the next edge.
- When no redirect is issued, new_pc_o = 0.
- Watchdog:
  - Increments each cycle stall_o[0]=1; clears on any cycle stall_o[0]=0.
  - Saturates at WDT_LIMIT.
  - On reaching WDT_LIMIT, hang_o sets and stays 1 until reset.
- Reset asserted mid-PEND discards the pending redirect.

Optional Feature:
- Macro STALL_PERF_CNT_EN.
- Defined: adds outputs stall_cycles_o[CNT_WIDTH-1:0] and flush_count_o[CNT_WIDTH-1:0].
  - stall_cycles_o counts cycles with stall_o[0]=1.
  - flush_count_o counts cycles with flush_o=1.
  - Both wrap modulo 2^CNT_WIDTH and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- The shared defines header holds:
  - stall-vector bit indices (StallPc..StallWb) and StallBus width;
  - the four stall patterns;
  - the FSM state encodings CtrlRun and CtrlPend;
  - InstAddrBus.
- One sub-module, stall_watchdog, contains the counter and the sticky hang flag, driven by stall_o[0].

Test Plan:
- IF then ID stall: stallreq_from_if=1 -> stall_o=000011. Next cycle add stallreq_from_id=1 -> stall_o=000111. Drop both -> 000000.
- Branch with no stall: branch_taken_i=1, target 0x00001040 -> same cycle flush_o=1, redirect_o=1, new_pc_o=0x00001040, stall_o=0.
- Branch during MEM stall: mem=1 for 3 cycles plus branch to 0x200 in the first cycle -> stall_o=011111 for 3 cycles, flush_o=0. In the 4th cycle flush_o=1, new_pc_o=0x200. A second branch_taken_i pulse in cycle 2 is ignored.
- Branch with ID stall: branch_taken_i=1 and stallreq_from_id=1 -> stall_o=000000, flush_o=1.
- Watchdog: WDT_LIMIT=8, stallreq_from_if held 8 cycles -> hang_o=1 after the 8th edge. Release -> hang_o stays 1. Pulse rst low -> hang_o=0.
- Reset in PEND: enter PEND, assert rst low for 1 cycle, drop mem stall -> flush_o and redirect_o never assert; with STALL_PERF_CNT_EN, flush_count_o=0.
